// File: rtl/adder_result_checker.sv
// rtl/adder_result_checker.sv - bit-serial golden check of a registered adder's sum and carry-out
module adder_result_checker #(
  parameter int ADDER_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [ADDER_WIDTH-1:0] iA,
  input  logic [ADDER_WIDTH-1:0] iB,
  input  logic                   iC,
  input  logic [ADDER_WIDTH-1:0] iSum,
  input  logic                   iCarry,
  output logic                   oCheckValid,
  output logic                   oMismatch,
  output logic [CNT_WIDTH-1:0]   oCheckCount,
  output logic [CNT_WIDTH-1:0]   oErrCount,
  output logic                   oStickyErr
);

  localparam int IDX_W = $clog2(ADDER_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADDER_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMPARE} state_t;

  state_t                 state;
  logic [ADDER_WIDTH-1:0] aReg;
  logic [ADDER_WIDTH-1:0] bReg;
  logic [ADDER_WIDTH-1:0] sumCap;
  logic                   carryCap;
  logic [ADDER_WIDTH-1:0] refSum;
  logic                   serCarry;
  logic [IDX_W-1:0]       idx;
  logic                   sumBit;
  logic                   nextCarry;
  logic                   mismatchNow;

  assign sumBit      = aReg[0] ^ bReg[0] ^ serCarry;
  assign nextCarry   = (aReg[0] & bReg[0]) | (aReg[0] & serCarry) | (bReg[0] & serCarry);
  assign mismatchNow = {serCarry, refSum} != {carryCap, sumCap};
  assign oReady      = (state == IDLE);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      aReg        <= '0;
      bReg        <= '0;
      sumCap      <= '0;
      carryCap    <= 1'b0;
      refSum      <= '0;
      serCarry    <= 1'b0;
      idx         <= '0;
      oCheckValid <= 1'b0;
      oMismatch   <= 1'b0;
      oCheckCount <= '0;
      oErrCount   <= '0;
      oStickyErr  <= 1'b0;
    end else begin
      oCheckValid <= 1'b0;
      case (state)
        IDLE: begin
          if (iValid) begin
            aReg     <= iA;
            bReg     <= iB;
            sumCap   <= iSum;
            carryCap <= iCarry;
            serCarry <= iC;
            idx      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // LSB-first ripple; reference sum fills from the MSB so bit 0 lands last
          refSum   <= {sumBit, refSum[ADDER_WIDTH-1:1]};
          serCarry <= nextCarry;
          aReg     <= aReg >> 1;
          bReg     <= bReg >> 1;
          idx      <= idx + 1'b1;
          if (idx == LAST_IDX) state <= COMPARE;
        end
        COMPARE: begin
          oCheckValid <= 1'b1;
          oMismatch   <= mismatchNow;
          if (~&oCheckCount) oCheckCount <= oCheckCount + 1'b1;
          if (mismatchNow) begin
            oStickyErr <= 1'b1;
            if (~&oErrCount) oErrCount <= oErrCount + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// tb/tb_adder_result_checker.sv - directed self-checking bench for adder_result_checker
module tb_adder_result_checker;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iValid = 1'b0;
  logic        iValid4 = 1'b0;
  logic [31:0] iA = '0, iB = '0, iSum = '0;
  logic        iC = 1'b0, iCarry = 1'b0;

  logic        oReady, oCheckValid, oMismatch, oStickyErr;
  logic [15:0] oCheckCount, oErrCount;
  logic        ready4, checkValid4, mismatch4, sticky4;
  logic [3:0]  checkCount4, errCount4;

  int nChecks = 0;
  int nErrors = 0;

  always #5 iClk = ~iClk;

  adder_result_checker #(.ADDER_WIDTH(32), .CNT_WIDTH(16)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
    .iA(iA), .iB(iB), .iC(iC), .iSum(iSum), .iCarry(iCarry),
    .oCheckValid(oCheckValid), .oMismatch(oMismatch),
    .oCheckCount(oCheckCount), .oErrCount(oErrCount), .oStickyErr(oStickyErr)
  );

  // narrow counters to reach saturation quickly
  adder_result_checker #(.ADDER_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .iClk(iClk), .iRst(iRst), .iValid(iValid4), .oReady(ready4),
    .iA(iA), .iB(iB), .iC(iC), .iSum(iSum), .iCarry(iCarry),
    .oCheckValid(checkValid4), .oMismatch(mismatch4),
    .oCheckCount(checkCount4), .oErrCount(errCount4), .oStickyErr(sticky4)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge iClk);
    #1;
  endtask

  task automatic doReset();
    iRst = 1'b1;
    stepCycle();
    stepCycle();
    iRst = 1'b0;
  endtask

  // one transaction on dut (sel=0) or dut4 (sel=1); lat = edges from acceptance to oCheckValid
  task automatic runCheck(input bit sel, input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [31:0] s, input logic co, output int lat, output logic mm);
    iA = a; iB = b; iC = c; iSum = s; iCarry = co;
    for (int k = 0; k < 100; k++) begin
      if (sel ? ready4 : oReady) break;
      stepCycle();
    end
    if (sel) iValid4 = 1'b1; else iValid = 1'b1;
    stepCycle();
    iValid = 1'b0; iValid4 = 1'b0;
    iA = $urandom; iB = $urandom; iSum = $urandom;
    lat = -1;
    mm = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      stepCycle();
      if (sel ? checkValid4 : oCheckValid) begin
        lat = k;
        mm = sel ? mismatch4 : oMismatch;
        break;
      end
    end
  endtask

  int          lat;
  logic        mm;
  logic [32:0] full;
  logic [31:0] ra, rb;
  logic        rc;

  initial begin
    int nAcc, lastAcc, cyc, badGaps, pulses, rdy;
    doReset();
    checkVal("rst_ready", oReady, 1);
    checkVal("rst_cv", oCheckValid, 0);
    checkVal("rst_mm", oMismatch, 0);
    checkVal("rst_cnt", oCheckCount, 0);
    checkVal("rst_err", oErrCount, 0);
    checkVal("rst_sticky", oStickyErr, 0);

    runCheck(0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1'b1, lat, mm);
    checkVal("pass_lat", lat, 33);
    checkVal("pass_mm", mm, 0);
    checkVal("pass_cnt", oCheckCount, 1);
    checkVal("pass_err", oErrCount, 0);
    checkVal("pass_sticky", oStickyErr, 0);
    checkVal("pass_ready", oReady, 1);
    stepCycle();
    checkVal("cv_one_cycle", oCheckValid, 0);

    runCheck(0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h1, 1'b1, lat, mm);
    checkVal("sumerr_mm", mm, 1);
    checkVal("sumerr_err", oErrCount, 1);
    checkVal("sumerr_sticky", oStickyErr, 1);
    checkVal("sumerr_cnt", oCheckCount, 2);

    runCheck(0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, lat, mm);
    checkVal("after_mm", mm, 0);
    checkVal("after_err", oErrCount, 1);
    checkVal("after_sticky", oStickyErr, 1);

    runCheck(0, 32'h80000000, 32'h80000000, 1'b0, 32'h0, 1'b0, lat, mm);
    checkVal("carryerr_mm", mm, 1);
    checkVal("carryerr_err", oErrCount, 2);

    // back-to-back with iValid held high
    doReset();
    ra = $urandom; rb = $urandom; rc = 1'($urandom);
    full = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
    iA = ra; iB = rb; iC = rc; iSum = full[31:0]; iCarry = full[32];
    iValid = 1'b1;
    nAcc = 0; lastAcc = 0; cyc = 0; badGaps = 0; pulses = 0;
    while (nAcc < 100 && cyc < 5000) begin
      rdy = oReady;
      stepCycle();
      cyc++;
      if (oCheckValid) pulses++;
      if (rdy != 0) begin
        if (nAcc > 0 && (cyc - lastAcc) != 34) badGaps++;
        lastAcc = cyc;
        nAcc++;
        ra = $urandom; rb = $urandom; rc = 1'($urandom);
        full = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
        iA = ra; iB = rb; iC = rc; iSum = full[31:0]; iCarry = full[32];
      end
    end
    iValid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      stepCycle();
      if (oCheckValid) pulses++;
    end
    checkVal("b2b_acc", nAcc, 100);
    checkVal("b2b_gaps", badGaps, 0);
    checkVal("b2b_pulses", pulses, 100);
    checkVal("b2b_cnt", oCheckCount, 100);
    checkVal("b2b_err", oErrCount, 0);

    // reset during the 10th SHIFT cycle
    doReset();
    iA = 32'h1; iB = 32'h1; iC = 1'b0; iSum = 32'h5; iCarry = 1'b0;
    iValid = 1'b1;
    stepCycle();
    iValid = 1'b0;
    for (int k = 0; k < 9; k++) stepCycle();
    iRst = 1'b1;
    stepCycle();
    iRst = 1'b0;
    checkVal("midrst_ready", oReady, 1);
    checkVal("midrst_cnt", oCheckCount, 0);
    checkVal("midrst_err", oErrCount, 0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (oCheckValid) pulses++;
      stepCycle();
    end
    checkVal("midrst_nopulse", pulses, 0);
    runCheck(0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1'b1, lat, mm);
    checkVal("midrst_pass_mm", mm, 0);
    checkVal("midrst_pass_cnt", oCheckCount, 1);

    // saturation with 4-bit counters
    for (int n = 0; n < 20; n++) begin
      runCheck(1, 32'h0, 32'h0, 1'b0, 32'h1, 1'b0, lat, mm);
    end
    checkVal("sat_mm", mm, 1);
    checkVal("sat_err", errCount4, 15);
    checkVal("sat_cnt", checkCount4, 15);
    checkVal("sat_sticky", sticky4, 1);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
